// File: rtl/cms_hot_filter_if.sv
// Access stream from the sketch side and the hot-address report handshake.
// The master drives accesses, sketch counts and hot_ready; the slave returns the report head.
interface cms_hot_filter_if #(
    parameter int NUM_HASH  = 4,
    parameter int ADDR_SIZE = 22,
    parameter int CNT_SIZE  = 32
);
    logic                 in_valid;
    logic [ADDR_SIZE-1:0] in_addr;
    logic [CNT_SIZE-1:0]  cnt_array [0:NUM_HASH-1];
    logic                 hot_valid;
    logic                 hot_ready;
    logic [ADDR_SIZE-1:0] hot_addr;
    logic [CNT_SIZE-1:0]  hot_cnt;

    modport master (
        output in_valid, in_addr, cnt_array, hot_ready,
        input  hot_valid, hot_addr, hot_cnt
    );

    modport slave (
        input  in_valid, in_addr, cnt_array, hot_ready,
        output hot_valid, hot_addr, hot_cnt
    );
endinterface

// File: rtl/cms_hot_filter.sv
// Reduces sketch counts to the count-min estimate, flags addresses whose estimate
// equals the threshold, and queues each such report in a first-word-fall-through FIFO.
module cms_hot_filter #(
    parameter int NUM_HASH   = 4,
    parameter int ADDR_SIZE  = 22,
    parameter int CNT_SIZE   = 32,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          query_rst_n,
    input  logic [CNT_SIZE-1:0]           threshold,
    cms_hot_filter_if.slave               bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   hot_total,
    output logic [31:0]                   drop_cnt
);
    localparam int LEVELS = $clog2(NUM_HASH);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int EW     = ADDR_SIZE + CNT_SIZE;

    logic                 align_valid [0:LATENCY-1];
    logic [ADDR_SIZE-1:0] align_addr  [0:LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                align_valid[i] <= 1'b0;
                align_addr[i]  <= '0;
            end
        end else begin
            align_valid[0] <= bus.in_valid && query_rst_n;
            align_addr[0]  <= bus.in_addr;
            for (int i = 1; i < LATENCY; i++) begin
                align_valid[i] <= align_valid[i-1] && query_rst_n;
                align_addr[i]  <= align_addr[i-1];
            end
        end
    end

    // Pairwise minimum tree, one generate level per halving.
    for (genvar lvl = 0; lvl <= LEVELS; lvl++) begin : g_lvl
        localparam int N = NUM_HASH >> lvl;
        logic [CNT_SIZE-1:0] node [0:N-1];
        for (genvar j = 0; j < N; j++) begin : g_node
            if (lvl == 0) begin : g_leaf
                assign node[j] = bus.cnt_array[j];
            end else begin : g_cmp
                assign node[j] = (g_lvl[lvl-1].node[2*j] < g_lvl[lvl-1].node[2*j+1])
                               ? g_lvl[lvl-1].node[2*j] : g_lvl[lvl-1].node[2*j+1];
            end
        end
    end

    logic [CNT_SIZE-1:0]  tree_min;
    assign tree_min = g_lvl[LEVELS].node[0];

    logic                 min_valid;
    logic [ADDR_SIZE-1:0] min_addr;
    logic [CNT_SIZE-1:0]  min_cnt;
    logic                 cmp_valid;
    logic [ADDR_SIZE-1:0] cmp_addr;
    logic [CNT_SIZE-1:0]  cmp_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_valid <= 1'b0;
            min_addr  <= '0;
            min_cnt   <= '0;
            cmp_valid <= 1'b0;
            cmp_addr  <= '0;
            cmp_cnt   <= '0;
        end else begin
            min_valid <= align_valid[LATENCY-1] && query_rst_n;
            min_addr  <= align_addr[LATENCY-1];
            min_cnt   <= tree_min;
            // Equality rather than >= keeps a report to once per epoch.
            cmp_valid <= min_valid && query_rst_n && (threshold != '0) && (min_cnt == threshold);
            cmp_addr  <= min_addr;
            cmp_cnt   <= min_cnt;
        end
    end

    logic [EW-1:0] mem [0:FIFO_DEPTH-1];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [EW-1:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop   = !empty && bus.hot_ready;
    assign push  = cmp_valid && (!full || pop);
    assign drop  = cmp_valid && !push;
    assign head  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= {cmp_addr, cmp_cnt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hot_total <= '0;
            drop_cnt  <= '0;
        end else if (!query_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hot_total <= '0;
            drop_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
            if (push && (hot_total != 32'hFFFF_FFFF)) begin
                hot_total <= hot_total + 32'd1;
            end
            if (drop && (drop_cnt != 32'hFFFF_FFFF)) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

    // Head is forced to zero when empty so stale entries never show on the bus.
    assign fifo_level    = wr_ptr - rd_ptr;
    assign bus.hot_valid = !empty;
    assign bus.hot_addr  = empty ? '0 : head[EW-1:CNT_SIZE];
    assign bus.hot_cnt   = empty ? '0 : head[CNT_SIZE-1:0];
endmodule

// File: tb/tb_cms_hot_filter.sv
// Bench for cms_hot_filter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based behavioural model.
module tb_cms_hot_filter;
    localparam int NH = 4, AW = 22, CW = 32, LAT = 3, DEPTH = 16;

    typedef logic [NH-1:0][CW-1:0] pvec_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [CW-1:0] mn;
        int            push_cyc;
        bit            qual;
    } pend_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [CW-1:0] cnt;
    } rep_t;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      query_rst_n = 1'b1;
    logic [CW-1:0]             threshold = '0;
    logic [$clog2(DEPTH):0]    fifo_level;
    logic [31:0]               hot_total;
    logic [31:0]               drop_cnt;

    cms_hot_filter_if #(.NUM_HASH(NH), .ADDR_SIZE(AW), .CNT_SIZE(CW)) bus ();

    cms_hot_filter #(
        .NUM_HASH(NH), .ADDR_SIZE(AW), .CNT_SIZE(CW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .query_rst_n(query_rst_n), .threshold(threshold),
        .bus(bus), .fifo_level(fifo_level), .hot_total(hot_total), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_fail = 0;
    int          cyc = 0;
    bit          cmp_en = 0;
    pend_t       pend[$];
    rep_t        mq[$];
    logic [31:0] m_total = 0, m_drop = 0;
    int          n_qual = 0;
    pvec_t       sched [64];
    bit          sched_v [64];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic pvec_t mk(input int a, input int b, input int c, input int d);
        pvec_t v;
        v[0] = CW'(a); v[1] = CW'(b); v[2] = CW'(c); v[3] = CW'(d);
        return v;
    endfunction

    function automatic logic [CW-1:0] vmin(input pvec_t v);
        logic [CW-1:0] m = v[0];
        for (int h = 1; h < NH; h++) if (v[h] < m) m = v[h];
        return m;
    endfunction

    // Effect of one clock edge on the reporting behaviour, from the access stream alone.
    task automatic model_step(input bit iv, input logic [AW-1:0] a, input pvec_t v,
                              input bit rdy, input logic [CW-1:0] thr, input bit qn);
        bit    pop, acc;
        pend_t e;
        if (!qn) begin
            mq.delete(); pend.delete();
            m_total = 0; m_drop = 0; n_qual = 0;
            return;
        end
        pop = (mq.size() > 0) && rdy;
        acc = 0;
        if (pend.size() > 0 && pend[0].push_cyc == cyc) begin
            e = pend.pop_front();
            if (e.qual) begin
                n_qual++;
                if (mq.size() < DEPTH || pop) begin
                    acc = 1;
                    if (m_total != 32'hFFFF_FFFF) m_total++;
                end else if (m_drop != 32'hFFFF_FFFF) m_drop++;
            end
        end
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back('{e.addr, e.mn});
        foreach (pend[i]) if (pend[i].push_cyc == cyc + 1) pend[i].qual = (thr != 0) && (pend[i].mn == thr);
        if (iv) pend.push_back('{a, vmin(v), cyc + LAT + 2, 1'b0});
    endtask

    task automatic step(input bit iv, input logic [AW-1:0] a, input pvec_t v,
                        input bit rdy, input logic [CW-1:0] thr, input bit qn);
        @(negedge clk); #1;
        bus.in_valid = iv; bus.in_addr = a; bus.hot_ready = rdy;
        threshold = thr; query_rst_n = qn;
        for (int h = 0; h < NH; h++)
            bus.cnt_array[h] = sched_v[cyc % 64] ? sched[cyc % 64][h] : CW'($urandom);
        sched_v[cyc % 64] = 0;
        if (iv) begin
            sched[(cyc + LAT) % 64] = v;
            sched_v[(cyc + LAT) % 64] = 1;
        end
        @(posedge clk);
        model_step(iv, a, v, rdy, thr, qn);
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy, input logic [CW-1:0] thr);
        for (int i = 0; i < n; i++) step(0, '0, '0, rdy, thr, 1);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("hot_valid", bus.hot_valid, mq.size() > 0);
            chk("fifo_level", fifo_level, mq.size());
            chk("hot_total", hot_total, m_total);
            chk("drop_cnt", drop_cnt, m_drop);
            if (mq.size() > 0) begin
                chk("hot_addr", bus.hot_addr, mq[0].addr);
                chk("hot_cnt", bus.hot_cnt, mq[0].cnt);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 0; bus.in_addr = '0; bus.hot_ready = 0;
        for (int h = 0; h < NH; h++) bus.cnt_array[h] = '0;
        for (int i = 0; i < 64; i++) sched_v[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst hot_valid", bus.hot_valid, 0);
        chk("rst hot_addr", bus.hot_addr, 0);
        chk("rst hot_cnt", bus.hot_cnt, 0);
        chk("rst fifo_level", fifo_level, 0);
        chk("rst hot_total", hot_total, 0);
        chk("rst drop_cnt", drop_cnt, 0);
        @(negedge clk); rst_n = 1; cmp_en = 1;

        // Single qualifying access: report appears six cycles after issue.
        step(1, 22'h12345, mk(5, 2, 7, 3), 0, 2, 1);
        idle(4, 0, 2);
        #1 chk("t1 early hot_valid", bus.hot_valid, 0);
        idle(1, 0, 2);
        #1;
        chk("t1 hot_valid", bus.hot_valid, 1);
        chk("t1 hot_addr", bus.hot_addr, 22'h12345);
        chk("t1 hot_cnt", bus.hot_cnt, 2);
        chk("t1 hot_total", hot_total, 1);
        idle(2, 1, 2);
        step(0, '0, '0, 1, 2, 0);

        // Minimum above threshold, then threshold disabled with zero counts.
        step(1, 22'h0abc, mk(5, 3, 7, 3), 1, 2, 1);
        idle(20, 1, 2);
        #1 chk("t2 hot_total", hot_total, 0);
        step(1, 22'h0abc, mk(0, 0, 0, 0), 1, 0, 1);
        idle(20, 1, 0);
        #1 chk("t2 thr0 hot_total", hot_total, 0);

        // Overfill with backpressure, then drain in order.
        step(0, '0, '0, 0, 4, 0);
        for (int i = 0; i < 17; i++) step(1, AW'(i), mk(9, 4, 6, 8), 0, 4, 1);
        idle(6, 0, 4);
        #1;
        chk("t3 fifo_level", fifo_level, 16);
        chk("t3 drop_cnt", drop_cnt, 1);
        chk("t3 hot_total", hot_total, 16);
        for (int i = 0; i < 16; i++) begin
            #1 chk("t3 drain addr", bus.hot_addr, i);
            idle(1, 1, 4);
        end
        #1 chk("t3 drained level", fifo_level, 0);

        // Full FIFO: push coinciding with a pop is accepted.
        step(0, '0, '0, 0, 4, 0);
        for (int i = 0; i < 16; i++) step(1, AW'(12'h100 + i), mk(4, 5, 6, 7), 0, 4, 1);
        step(1, 22'h200, mk(7, 6, 5, 4), 0, 4, 1);
        idle(LAT + 1, 0, 4);
        idle(1, 1, 4);
        #1;
        chk("t4 fifo_level", fifo_level, 16);
        chk("t4 drop_cnt", drop_cnt, 0);
        chk("t4 hot_total", hot_total, 17);
        chk("t4 head", bus.hot_addr, 22'h101);
        idle(20, 1, 4);

        // Epoch clear with two queued reports and three in flight.
        step(0, '0, '0, 0, 4, 0);
        for (int i = 0; i < 5; i++) step(1, AW'(12'h300 + i), mk(4, 4, 4, 4), 0, 4, 1);
        idle(2, 0, 4);
        #1 chk("t5 pre level", fifo_level, 2);
        step(0, '0, '0, 0, 4, 0);
        idle(10, 1, 4);
        #1;
        chk("t5 hot_valid", bus.hot_valid, 0);
        chk("t5 fifo_level", fifo_level, 0);
        chk("t5 hot_total", hot_total, 0);
        chk("t5 drop_cnt", drop_cnt, 0);

        // Randomized stream with random backpressure, threshold changes and epoch clears.
        begin
            logic [CW-1:0] thr = 2;
            for (int c = 0; c < 3000; c++) begin
                pvec_t v;
                if ($urandom_range(0, 49) == 0) thr = CW'($urandom_range(0, 4));
                for (int h = 0; h < NH; h++) v[h] = CW'($urandom_range(0, 6));
                step($urandom_range(0, 9) < 7, AW'($urandom), v,
                     $urandom_range(0, 2) == 0, thr, $urandom_range(0, 299) != 0);
            end
            idle(40, 1, thr);
        end
        #1 chk("rand total+drop", hot_total + drop_cnt, n_qual);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
